mips_load_store_unit: RTL
=========================

Name: mips_load_store_unit

Overview:
Data-side bus initiator between the CPU execute stage and the Harvard RAM data port. It accepts one load/store request at a time and computes the word-aligned address, byteenable and lane-shifted write data. It drives the read or write strobe, waits out the RAM's read latency, then extracts and extends the load result. The data model is little-endian: the byte at addr[1:0]=k occupies bits 8k+7:8k and byteenable[k].

Parameters:
READ_LATENCY, 1, cycles from data_read sampled high to data_readdata valid; legal range 1..4.

Ports:
clk  in  1  clock; all state changes on the rising edge
reset_n  in  1  synchronous reset, active-low
req_valid  in  1  CPU request present
req_ready  out  1  unit can accept a request this cycle
req_op  in  4  lsu_op_t: LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW
req_addr  in  32  byte address
req_wdata  in  32  store data (rt)
req_rt  in  32  current rt value, merged by LWL/LWR
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  load result; 0 for stores and errors
resp_err  out  1  misaligned access; no bus transaction issued
data_address  out  32  {addr[31:2],2'b00}
data_read  out  1  read strobe
data_write  out  1  write strobe
byteenable  out  4  lane enables for writes; 4'b1111 on reads
data_writedata  out  32  lane-replicated store data
data_readdata  in  32  RAM read data

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP.
- req_ready = (state==IDLE) && reset_n.
- Accept on req_valid && req_ready. Latch op, addr, wdata and rt into registers, and compute the misalignment flag at accept:
  - misaligned: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - never misaligned: LB/LBU/SB/LWL/LWR.
- IDLE→ACCESS on accept.
- ACCESS, lasts exactly one cycle:
  - misaligned: all strobes 0; resp_valid=1, resp_err=1, resp_rdata=0; next state IDLE.
  - store: data_write=1 for this cycle only. resp_valid=1, resp_err=0, resp_rdata=0 in the same cycle; next state IDLE.
  - load: data_read=1 for this cycle only; load latency counter set to READ_LATENCY-1; next state WAIT.
- WAIT:
  - counter>0: decrement each cycle.
  - counter==0: capture data_readdata into an internal register; go to RESP.
  - strobes are 0 throughout WAIT.
- RESP: resp_valid=1 with the extracted result; next state IDLE. Load latency is therefore accept + 2 + READ_LATENCY cycles; store latency is accept + 1.
- Responses have no backpressure; the consumer must take resp_valid when it pulses.
- Store lanes:
  - SB: byteenable=1<<k; writedata={4{wdata[7:0]}}.
  - SH: byteenable is 0011 (k=0) or 1100 (k=2); writedata={2{wdata[15:0]}}.
  - SW: byteenable=1111; writedata=wdata.
- Load extract, with m = captured word and k = addr[1:0]:
  - LB/LBU: byte k, sign- or zero-extended to 32.
  - LH/LHU: halfword k/2, sign- or zero-extended to 32.
  - LW: m.
  - LWL: k=0 {m[7:0],rt[23:0]}; k=1 {m[15:0],rt[15:0]}; k=2 {m[23:0],rt[7:0]}; k=3 m.
  - LWR: k=0 m; k=1 {rt[31:24],m[31:8]}; k=2 {rt[31:16],m[31:16]}; k=3 {rt[31:8],m[31:24]}.
- data_read and data_write are never high together.
- Outside ACCESS, bus outputs are registered:
  - data_address, data_writedata and byteenable hold 0.
  - resp_rdata holds 0; resp_err holds 0.
- Reset, checked every edge with reset_n=0:
  - state←IDLE and all registers cleared, so every output is 0.
  - A reset mid-transaction aborts it: no resp_valid is produced, and strobes drop at that edge.
- req_valid while not ready is ignored; the requester holds the request.
- An illegal req_op encoding is treated as misaligned (resp_err=1).

Decomposition:
- Package mips_lsu_pkg: lsu_op_t enum (4-bit), lsu_state_t enum, and the function is_misaligned(op, addr[1:0]).
- Sub-module mips_load_extract: combinational op/k/m/rt → 32-bit result. It is unit-tested separately.
- Store lane generation stays inline.

Test Plan:
1. SW addr 0xBFC00010 wdata 0xDEADBEEF → one cycle after accept: data_write=1, address 0xBFC00010, byteenable 1111, writedata 0xDEADBEEF, resp_valid=1 with err=0.
2. SB addr 0xBFC00013 wdata 0x000000AB → byteenable 1000, writedata 0xABABABAB. A following LW of 0xBFC00010 with RAM returning 0xABADBEEF → resp_rdata 0xABADBEEF, 3 cycles after accept (READ_LATENCY=1).
3. With RAM word 0x8001FF7F: LB k=0 → 0x0000007F; LB k=1 → 0xFFFFFFFF; LBU k=1 → 0x000000FF; LH k=2 → 0xFFFF8001; LHU k=2 → 0x00008001.
4. LWL k=1 and LWR k=1 with rt=0x11223344 and m=0xAABBCCDD → LWL 0xCCDD3344, LWR 0x11AABBCC.
5. LW addr 0x…02 and SH addr 0x…01 → resp_err=1, resp_rdata=0, no strobe ever asserted, req_ready back high the cycle after.
6. READ_LATENCY=3: the capture uses data_readdata three cycles after data_read. Separately, asserting reset_n=0 during WAIT → no resp_valid, all outputs 0, req_ready=1 the cycle after reset_n rises.

Source files
------------

// File: rtl/mips_lsu_pkg.sv
// Shared types and decode helpers for the MIPS data-side load/store unit.
package mips_lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'd0,
      OP_LBU = 4'd1,
      OP_LH  = 4'd2,
      OP_LHU = 4'd3,
      OP_LW  = 4'd4,
      OP_LWL = 4'd5,
      OP_LWR = 4'd6,
      OP_SB  = 4'd7,
      OP_SH  = 4'd8,
      OP_SW  = 4'd9
   } lsu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP
   } lsu_state_t;

   // Alignment violation for the access size; unknown encodings are rejected the same way.
   function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] a);
      case (lsu_op_t'(op))
         OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR: is_misaligned = 1'b0;
         OP_LH, OP_LHU, OP_SH:                 is_misaligned = a[0];
         OP_LW, OP_SW:                         is_misaligned = (a != 2'b00);
         default:                              is_misaligned = 1'b1;
      endcase
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      is_store = (lsu_op_t'(op) inside {OP_SB, OP_SH, OP_SW});
   endfunction

endpackage

// File: rtl/mips_load_extract.sv
// Load result formatter: selects the addressed byte/halfword from the RAM word
// and extends it, or merges it with rt for the unaligned LWL/LWR pair.
module mips_load_extract
   import mips_lsu_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [1:0]  k,
   input  logic [31:0] m,
   input  logic [31:0] rt,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane, then extend or merge according to the opcode.
   always_comb begin
      // NOTE: every variable gets a value before the case so no path leaves it unassigned; otherwise a latch is inferred.
      result   = 32'h0;
      byte_sel = m[{k, 3'b000} +: 8];
      half_sel = k[1] ? m[31:16] : m[15:0];
      case (lsu_op_t'(op))
         OP_LB:  result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: result = {24'h0, byte_sel};
         OP_LH:  result = {{16{half_sel[15]}}, half_sel};
         OP_LHU: result = {16'h0, half_sel};
         OP_LW:  result = m;
         OP_LWL: begin
            case (k)
               2'd0:    result = {m[7:0],  rt[23:0]};
               2'd1:    result = {m[15:0], rt[15:0]};
               2'd2:    result = {m[23:0], rt[7:0]};
               default: result = m;
            endcase
         end
         OP_LWR: begin
            case (k)
               2'd0:    result = m;
               2'd1:    result = {rt[31:24], m[31:8]};
               2'd2:    result = {rt[31:16], m[31:16]};
               default: result = {rt[31:8],  m[31:24]};
            endcase
         end
         default: result = 32'h0;
      endcase
   end

endmodule

// File: rtl/mips_load_store_unit.sv
// Data-side bus initiator: one load/store at a time, word-aligned bus address,
// lane-shifted store data, fixed read latency, extracted load result.
module mips_load_store_unit
   import mips_lsu_pkg::*;
#(
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_rt,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] data_address,
   output logic        data_read,
   output logic        data_write,
   output logic [3:0]  byteenable,
   output logic [31:0] data_writedata,
   input  logic [31:0] data_readdata
);

   lsu_state_t  state;
   logic [3:0]  op_q;
   logic [1:0]  k_q;
   logic [31:0] rt_q;
   logic        load_q;
   logic [1:0]  lat_cnt;
   logic        misaligned;
   logic        store_op;
   logic [3:0]  store_be;
   logic [31:0] store_wd;
   logic [31:0] ext_result;

   assign req_ready  = (state == ST_IDLE) && reset_n;
   assign misaligned = is_misaligned(req_op, req_addr[1:0]);
   assign store_op   = is_store(req_op);

   // Store lane enables and replicated write data for the incoming request.
   always_comb begin
      store_be = 4'b0000;
      store_wd = 32'h0;
      case (lsu_op_t'(req_op))
         OP_SB: begin
            store_be = 4'b0001 << req_addr[1:0];
            store_wd = {4{req_wdata[7:0]}};
         end
         OP_SH: begin
            store_be = req_addr[1] ? 4'b1100 : 4'b0011;
            store_wd = {2{req_wdata[15:0]}};
         end
         OP_SW: begin
            store_be = 4'b1111;
            store_wd = req_wdata;
         end
         default: ;
      endcase
   end

   mips_load_extract u_extract (
      .op     (op_q),
      .k      (k_q),
      .m      (data_readdata),
      .rt     (rt_q),
      .result (ext_result)
   );

   // Transaction FSM; bus and response outputs are registered and pulse for one cycle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         op_q           <= 4'h0;
         k_q            <= 2'b00;
         rt_q           <= 32'h0;
         load_q         <= 1'b0;
         lat_cnt        <= 2'd0;
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'h0;
         resp_err       <= 1'b0;
         data_address   <= 32'h0;
         data_read      <= 1'b0;
         data_write     <= 1'b0;
         byteenable     <= 4'b0000;
         data_writedata <= 32'h0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
         resp_valid     <= 1'b0;
         resp_rdata     <= 32'h0;
         resp_err       <= 1'b0;
         data_address   <= 32'h0;
         data_read      <= 1'b0;
         data_write     <= 1'b0;
         byteenable     <= 4'b0000;
         data_writedata <= 32'h0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q   <= req_op;
                  k_q    <= req_addr[1:0];
                  rt_q   <= req_rt;
                  load_q <= 1'b0;
                  state  <= ST_ACCESS;
                  if (misaligned) begin
                     // Rejected without touching the bus; error response in the access cycle.
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (store_op) begin
                     // Stores complete in the same cycle the write strobe is on the bus.
                     data_write     <= 1'b1;
                     data_address   <= {req_addr[31:2], 2'b00};
                     byteenable     <= store_be;
                     data_writedata <= store_wd;
                     resp_valid     <= 1'b1;
                  end else begin
                     data_read    <= 1'b1;
                     data_address <= {req_addr[31:2], 2'b00};
                     byteenable   <= 4'b1111;
                     load_q       <= 1'b1;
                  end
               end
            end
            ST_ACCESS: begin
               lat_cnt <= 2'(READ_LATENCY - 1);
               state   <= load_q ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
               if (lat_cnt != 2'd0) begin
                  lat_cnt <= lat_cnt - 2'd1;
               end else begin
                  // The RAM word is formatted as it is captured; RESP presents the result.
                  resp_rdata <= ext_result;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
